// File: rtl/vit_pkg.sv
// Shared constants for the Viterbi receive path: code-rate encodings, puncture
// periods and the per-phase erasure masks used by the depuncturer and BMU.
package vit_pkg;

    localparam logic [1:0] RATE_12  = 2'b00;
    localparam logic [1:0] RATE_23  = 2'b01;
    localparam logic [1:0] RATE_34  = 2'b10;
    localparam logic [1:0] RATE_ILL = 2'b11;

    localparam int PERIOD_12 = 2;
    localparam int PERIOD_23 = 3;
    localparam int PERIOD_34 = 4;

    // Erase masks are {A, B}; a set bit marks a punctured position.
    localparam logic [1:0] ERASE_NONE = 2'b00;
    localparam logic [1:0] ERASE_B    = 2'b01;
    localparam logic [1:0] ERASE_A    = 2'b10;

    function automatic logic [1:0] last_phase(input logic [1:0] rate);
        int period;
        case (rate)
            RATE_23: period = PERIOD_23;
            RATE_34: period = PERIOD_34;
            default: period = PERIOD_12;
        endcase
        return 2'(period - 1);
    endfunction

endpackage

// File: rtl/depuncturer.sv
// Re-inserts 802.11a punctured bits and emits one (A,B) pair with erasure
// flags per completed pair, registered, for the Viterbi decoder input.
module depuncturer
    import vit_pkg::*;
(
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iStart,
    input  logic [1:0] iRate,
    input  logic       iValid,
    input  logic       iBit,
    input  logic       iLast,
    output logic [1:0] oData,
    output logic [1:0] oErase,
    output logic       oValid,
    output logic       oLast,
    output logic       oRateErr
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0] state;
    logic [1:0] phase;
    logic [1:0] rate_q;
    logic       held;

    logic       start;
    logic       take;
    logic [1:0] rate_new;
    logic [1:0] rate_eff;
    logic [1:0] ph_eff;
    logic [1:0] ph_next;
    logic       emit;
    logic [1:0] pair;
    logic [1:0] era;

    always_comb begin
        start    = iValid & iStart;
        take     = iValid & (iStart | (state == ST_RUN));
        rate_new = (iRate == RATE_ILL) ? RATE_12 : iRate;
        // A start bit is always phase 0 of the newly latched rate.
        rate_eff = start ? rate_new : rate_q;
        ph_eff   = start ? 2'd0 : phase;
        ph_next  = (ph_eff == last_phase(rate_eff)) ? 2'd0 : ph_eff + 2'd1;

        emit = 1'b0;
        pair = 2'b00;
        era  = ERASE_NONE;
        case (ph_eff)
            2'd0: begin
                if (iLast) begin
                    emit = 1'b1;
                    pair = {iBit, 1'b0};
                    era  = ERASE_B;
                end
            end
            2'd1: begin
                emit = 1'b1;
                pair = {held, iBit};
                era  = ERASE_NONE;
            end
            2'd2: begin
                if (rate_eff != RATE_12) begin
                    emit = 1'b1;
                    pair = {iBit, 1'b0};
                    era  = ERASE_B;
                end
            end
            default: begin
                if (rate_eff == RATE_34) begin
                    emit = 1'b1;
                    pair = {1'b0, iBit};
                    era  = ERASE_A;
                end
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            state    <= ST_IDLE;
            phase    <= 2'd0;
            rate_q   <= RATE_12;
            held     <= 1'b0;
            oData    <= 2'b00;
            oErase   <= 2'b00;
            oValid   <= 1'b0;
            oLast    <= 1'b0;
            oRateErr <= 1'b0;
        end else begin
            oValid <= 1'b0;
            oLast  <= 1'b0;
            if (take) begin
                if (emit) begin
                    oValid <= 1'b1;
                    oData  <= pair;
                    oErase <= era;
                    oLast  <= iLast;
                end
                if (ph_eff == 2'd0)
                    held <= iBit;
                if (start) begin
                    rate_q   <= rate_new;
                    oRateErr <= (iRate == RATE_ILL);
                end
                if (iLast) begin
                    state <= ST_IDLE;
                    phase <= 2'd0;
                end else begin
                    state <= ST_RUN;
                    phase <= ph_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_depuncturer.sv
// Scoreboard bench for depuncturer: directed frames push expected pairs,
// a negedge monitor pops and compares each oValid strobe.
module tb_depuncturer;

    logic       iClk = 1'b0;
    logic       iRst = 1'b0;
    logic       iStart = 1'b0;
    logic [1:0] iRate = 2'b00;
    logic       iValid = 1'b0;
    logic       iBit = 1'b0;
    logic       iLast = 1'b0;
    logic [1:0] oData;
    logic [1:0] oErase;
    logic       oValid;
    logic       oLast;
    logic       oRateErr;

    typedef struct {
        logic [1:0] d;
        logic [1:0] e;
        logic       l;
        int         c;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    depuncturer dut (
        .iClk(iClk), .iRst(iRst), .iStart(iStart), .iRate(iRate),
        .iValid(iValid), .iBit(iBit), .iLast(iLast),
        .oData(oData), .oErase(oErase), .oValid(oValid),
        .oLast(oLast), .oRateErr(oRateErr)
    );

    always #5 iClk = ~iClk;
    always @(posedge iClk) cyc <= cyc + 1;

    always @(negedge iClk) begin
        if (oValid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_pair: got data=%b erase=%b last=%b cyc=%0d, expected no pair",
                         oData, oErase, oLast, cyc);
            end else begin
                exp_t x;
                x = sb.pop_front();
                if (oData !== x.d || oErase !== x.e || oLast !== x.l || cyc != x.c) begin
                    errors++;
                    $display("FAIL pair: got data=%b erase=%b last=%b cyc=%0d, expected data=%b erase=%b last=%b cyc=%0d",
                             oData, oErase, oLast, cyc, x.d, x.e, x.l, x.c);
                end
            end
        end
    end

    task automatic drive(input logic st, input logic [1:0] rt, input logic b,
                         input logic lst, input logic v, input logic ex,
                         input logic [1:0] d, input logic [1:0] e);
        exp_t x;
        iStart = st; iRate = rt; iBit = b; iLast = lst; iValid = v;
        if (ex) begin
            x.d = d; x.e = e; x.l = lst; x.c = cyc + 1;
            sb.push_back(x);
        end
        @(posedge iClk); #1;
        iStart = 1'b0; iValid = 1'b0; iLast = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge iClk); #1;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        idle(3);
        check("reset_outputs", {1'b0, oValid, oLast, oRateErr, oErase, oData}, 8'h00);
        iRst = 1'b1;
        idle(1);

        // bits arriving in IDLE without a start are dropped
        drive(0, 2'b00, 1, 0, 1, 0, 2'b00, 2'b00);
        drive(0, 2'b00, 1, 0, 1, 0, 2'b00, 2'b00);
        idle(1);

        // rate 1/2: 1,0,1,1
        drive(1, 2'b00, 1, 0, 1, 0, 2'b00, 2'b00);
        drive(0, 2'b00, 0, 0, 1, 1, 2'b10, 2'b00);
        drive(0, 2'b00, 1, 0, 1, 0, 2'b00, 2'b00);
        drive(0, 2'b00, 1, 1, 1, 1, 2'b11, 2'b00);
        idle(2);
        check("data_hold", {2'b00, oValid, oLast, oErase, oData}, 8'h03);

        // rate 3/4: 1,1,0,1 with last
        drive(1, 2'b10, 1, 0, 1, 0, 2'b00, 2'b00);
        drive(0, 2'b10, 1, 0, 1, 1, 2'b11, 2'b00);
        drive(0, 2'b01, 0, 0, 1, 1, 2'b00, 2'b01);
        drive(0, 2'b00, 1, 1, 1, 1, 2'b01, 2'b10);
        idle(2);

        // rate 2/3, last lands on phase 0
        drive(1, 2'b01, 1, 0, 1, 0, 2'b00, 2'b00);
        drive(0, 2'b01, 0, 0, 1, 1, 2'b10, 2'b00);
        drive(0, 2'b01, 1, 0, 1, 1, 2'b10, 2'b01);
        drive(0, 2'b01, 1, 1, 1, 1, 2'b10, 2'b01);
        idle(2);

        // illegal rate behaves as 1/2 and flags an error
        drive(1, 2'b11, 1, 0, 1, 0, 2'b00, 2'b00);
        check("rate_err_set", {7'd0, oRateErr}, 8'h01);
        drive(0, 2'b11, 0, 0, 1, 1, 2'b10, 2'b00);
        drive(0, 2'b10, 1, 0, 1, 0, 2'b00, 2'b00);
        drive(0, 2'b10, 1, 1, 1, 1, 2'b11, 2'b00);
        idle(1);
        check("rate_err_sticky", {7'd0, oRateErr}, 8'h01);

        // legal-rate start clears the error; 3/4 frame ending on phase 2
        drive(1, 2'b10, 0, 0, 1, 0, 2'b00, 2'b00);
        check("rate_err_clear", {7'd0, oRateErr}, 8'h00);
        drive(0, 2'b10, 1, 0, 1, 1, 2'b01, 2'b00);
        drive(0, 2'b10, 1, 1, 1, 1, 2'b10, 2'b01);
        idle(2);

        // restart after one held bit: held bit produces nothing
        drive(1, 2'b00, 1, 0, 1, 0, 2'b00, 2'b00);
        drive(1, 2'b00, 0, 0, 1, 0, 2'b00, 2'b00);
        drive(0, 2'b00, 1, 1, 1, 1, 2'b01, 2'b00);
        idle(2);

        // one-bit frame: start and last together
        drive(1, 2'b10, 1, 1, 1, 1, 2'b10, 2'b01);
        idle(2);

        // rate 3/4 with a 5-cycle gap between bits 2 and 3
        drive(1, 2'b10, 1, 0, 1, 0, 2'b00, 2'b00);
        drive(0, 2'b10, 1, 0, 1, 1, 2'b11, 2'b00);
        drive(0, 2'b10, 1, 0, 0, 0, 2'b00, 2'b00);
        idle(4);
        drive(0, 2'b10, 0, 0, 1, 1, 2'b00, 2'b01);
        drive(0, 2'b10, 1, 1, 1, 1, 2'b01, 2'b10);
        idle(2);

        // reset mid-frame clears outputs on the next cycle
        drive(1, 2'b11, 1, 0, 1, 0, 2'b00, 2'b00);
        drive(0, 2'b11, 1, 0, 1, 1, 2'b11, 2'b00);
        iRst = 1'b0;
        iValid = 1'b1; iBit = 1'b1;
        @(posedge iClk); #1;
        iValid = 1'b0;
        check("mid_reset_outputs", {1'b0, oValid, oLast, oRateErr, oErase, oData}, 8'h00);
        iRst = 1'b1;
        // after reset the FSM is idle, so a lone bit is dropped
        drive(0, 2'b00, 1, 0, 1, 0, 2'b00, 2'b00);
        drive(0, 2'b00, 1, 1, 1, 0, 2'b00, 2'b00);
        idle(3);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_pairs: got %0d outstanding, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/depuncturer.md
Name: depuncturer

Overview:
- Sits directly upstream of vitDecoder; consumes the serial coded-bit stream from the deinterleaver.
- Re-inserts the bits removed by 802.11a puncturing for rates 2/3 and 3/4.
- Emits one (A,B) code pair per strobe, with a per-bit erasure flag, to drive the decoder's iData/iEN.

Parameters:
- None. Puncture patterns are fixed by 802.11a and held in the shared package.

Ports:
- iClk  in  1  single system clock.
- iRst  in  1  synchronous, active-low reset.
- iStart  in  1  frame-start pulse; latches iRate; accepted only together with iValid.
- iRate  in  2  code rate: 00=1/2, 01=2/3, 10=3/4, 11=illegal.
- iValid  in  1  iBit carries a coded bit this cycle.
- iBit  in  1  received coded bit.
- iLast  in  1  marks the last coded bit of the frame; accepted only together with iValid.
- oData  out  2  [1]=A, [0]=B; an erased position drives 0.
- oErase  out  2  [1]=A erased, [0]=B erased.
- oValid  out  1  oData/oErase valid this cycle; wired to the decoder's iEN.
- oLast  out  1  marks the final pair of the frame; valid with oValid.
- oRateErr  out  1  sticky flag; set when iRate=11 is latched.

Behaviour:
- Reset (iRst=0 at a clock edge):
  - oData=00, oErase=00, oValid=0, oLast=0, oRateErr=0.
  - Phase counter=0, latched rate=1/2, held-bit register cleared, FSM to IDLE.
- FSM states: IDLE, RUN.
  - IDLE->RUN on iStart&iValid. That same bit is the phase-0 bit.
  - RUN->IDLE after the bit with iLast is processed.
  - Bits with iValid in IDLE and without iStart are dropped.
  - iStart&iValid in RUN restarts the frame: phase=0, rate re-latched, held bit discarded, no output for the partial pair.
- Rate latch:
  - Sampled only on iStart; iRate changes mid-frame are ignored.
  - 11 is treated as 1/2 and sets oRateErr. oRateErr clears only on reset or on an iStart with a legal rate.
- Phase sequence per accepted bit, and the pair emitted:
  - Rate 1/2, phases 0..1:
    - Ph0: hold bit as A.
    - Ph1: emit (A, bit), erase 00.
  - Rate 2/3, phases 0..2:
    - Ph0: hold A0.
    - Ph1: emit (A0, bit), erase 00.
    - Ph2: emit (bit, 0), erase 01.
  - Rate 3/4, phases 0..3:
    - Ph0: hold A0.
    - Ph1: emit (A0, bit), erase 00.
    - Ph2: emit (bit, 0), erase 01.
    - Ph3: emit (0, bit), erase 10.
  - The phase wraps to 0 after its last value.
- Output timing:
  - Outputs are registered; latency is 1 cycle from the accepted bit that completes a pair.
  - At most one pair per cycle. No backpressure is needed because output pairs never exceed input bits.
  - oValid is a single-cycle strobe per pair. oData and oErase hold their values when oValid=0.
- End of frame:
  - If iLast arrives on a phase that emits, that pair carries oLast=1.
  - If iLast arrives on a hold phase (Ph0), emit (A, 0) with erase 01 and oLast=1 next cycle.
- Simultaneous events: when iStart&iLast&iValid occur together, this is a one-bit frame; it follows the Ph0 iLast rule.
- Reset mid-frame: outputs are cleared the next cycle and no partial pair is emitted.
- iValid gaps: any number of idle cycles between bits is allowed; phase and held bit are preserved.

Decomposition:
- Package vit_pkg holds:
  - the rate codes RATE_12, RATE_23, RATE_34;
  - the per-rate period (2,3,4);
  - per-phase erase masks as constants;
  - shared with the TBU/PMU for the erasure-aware BMU extension.
- A single flat module; no sub-module is warranted.
- Implementation: pattern lookup is a case on {rate, phase}, plus one small FSM and a 2-bit phase counter.

Test Plan:
- Rate 1/2: iStart plus bits 1,0,1,1 -> two pairs (10, erase 00) then (11, erase 00), each 1 cycle after bits 2 and 4; oLast set on the second pair.
- Rate 3/4: bits 1,1,0,1, last on bit 4 -> pairs (11,00), (00,01), (01,10); oLast on the third; oValid pulses on cycles +2,+3,+4 from start.
- Rate 2/3 with iLast on a Ph0 bit (4 bits: 1,0,1,1) -> pairs (10,00), (10,01), (10,01) with oLast=1 on the third.
- iRate=11 at iStart -> behaves exactly as 1/2 and oRateErr=1; a next frame with iRate=10 clears oRateErr.
- Mid-frame iStart after one held bit -> no pair emitted for the held bit and the new frame decodes from phase 0. Separately, iRst=0 mid-frame clears all outputs next cycle.
- Rate 3/4 with iValid deasserted for 5 cycles between bits 2 and 3 -> the same pairs as the contiguous case, with no spurious oValid.
